// File: rtl/sdram_arb.sv
// Two-port request arbiter and command front-end for the SDRAM controller.
// Port A (Saturn bus) wins by default; RR=1 alternates between ports on contention.
`timescale 1ns/1ps
module sdram_arb #(
   parameter bit RR      = 1'b0,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_wr,
   input  logic        a_byte,
   input  logic [31:0] a_addr,
   input  logic [15:0] a_wdata,
   output logic [15:0] a_rdata,
   output logic        a_done,
   input  logic        b_req,
   input  logic        b_wr,
   input  logic        b_byte,
   input  logic [31:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic [15:0] b_rdata,
   output logic        b_done,
   output logic [1:0]  cmd_req,
   input  logic        cmd_ack,
   output logic [1:0]  cmd_mask,
   output logic [31:0] cmd_addr,
   output logic [15:0] cmd_din,
   input  logic [15:0] cmd_dout,
   input  logic        data_valid,
   output logic        busy,
   output logic        rd_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RDAT, ST_DRAIN} state_e;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        sel_q, sel_d;
   logic        wr_q, wr_d;
   logic        prio_q, prio_d;
   logic [1:0]  cmdReq_q, cmdReq_d;
   logic [1:0]  cmdMask_q, cmdMask_d;
   logic [31:0] cmdAddr_q, cmdAddr_d;
   logic [15:0] cmdDin_q, cmdDin_d;
   logic [15:0] aRdata_q, aRdata_d;
   logic [15:0] bRdata_q, bRdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        aDone_q, aDone_d;
   logic        bDone_q, bDone_d;
   logic        rdErr_q, rdErr_d;

   logic        pickB;
   logic        winWr;
   logic        winByte;
   logic [31:0] winAddr;
   logic [15:0] winData;

   // prio_q=1 means B is preferred on a tie (A was granted last)
   always_comb begin
      pickB = 1'b0;
      if (a_req && b_req) begin
         pickB = RR ? prio_q : 1'b0;
      end else begin
         pickB = b_req;
      end
   end

   assign winWr   = pickB ? b_wr    : a_wr;
   assign winByte = pickB ? b_byte  : a_byte;
   assign winAddr = pickB ? b_addr  : a_addr;
   assign winData = pickB ? b_wdata : a_wdata;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      wr_d      = wr_q;
      prio_d    = prio_q;
      cmdReq_d  = cmdReq_q;
      cmdMask_d = cmdMask_q;
      cmdAddr_d = cmdAddr_q;
      cmdDin_d  = cmdDin_q;
      aRdata_d  = aRdata_q;
      bRdata_d  = bRdata_q;
      cnt_d     = cnt_q;
      aDone_d   = 1'b0;
      bDone_d   = 1'b0;
      rdErr_d   = rdErr_q;
      case (state_q)
         // No grant during a done cycle: the finished requester still holds its req
         ST_IDLE: begin
            if ((a_req || b_req) && !(aDone_q || bDone_q)) begin
               sel_d     = pickB;
               prio_d    = ~pickB;
               wr_d      = winWr;
               cmdAddr_d = winAddr;
               cmdMask_d = 2'b00;
               if (!winWr) begin
                  cmdReq_d = 2'b10;
               end else if (winByte) begin
                  cmdReq_d  = 2'b01;
                  cmdDin_d  = {winData[7:0], winData[7:0]};
                  cmdMask_d = winAddr[0] ? 2'b10 : 2'b01;
               end else begin
                  cmdReq_d = 2'b11;
                  cmdDin_d = winData;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ack) begin
               cmdReq_d = 2'b00;
               if (wr_q) begin
                  aDone_d = ~sel_q;
                  bDone_d = sel_q;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = 8'd0;
                  state_d = ST_RDAT;
               end
            end
         end
         ST_RDAT: begin
            if (data_valid) begin
               if (sel_q) begin
                  bRdata_d = cmd_dout;
               end else begin
                  aRdata_d = cmd_dout;
               end
               aDone_d = ~sel_q;
               bDone_d = sel_q;
               state_d = ST_DRAIN;
            end else if (cnt_q == TimeoutLast) begin
               rdErr_d = 1'b1;
               aDone_d = ~sel_q;
               bDone_d = sel_q;
               state_d = ST_IDLE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         // Let the rest of the burst pass so the next read cannot latch a stale word
         ST_DRAIN: begin
            if (!data_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sel_q     <= 1'b0;
         wr_q      <= 1'b0;
         prio_q    <= 1'b0;
         cmdReq_q  <= 2'b00;
         cmdMask_q <= 2'b00;
         cmdAddr_q <= 32'd0;
         cmdDin_q  <= 16'd0;
         aRdata_q  <= 16'd0;
         bRdata_q  <= 16'd0;
         cnt_q     <= 8'd0;
         aDone_q   <= 1'b0;
         bDone_q   <= 1'b0;
         rdErr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         wr_q      <= wr_d;
         prio_q    <= prio_d;
         cmdReq_q  <= cmdReq_d;
         cmdMask_q <= cmdMask_d;
         cmdAddr_q <= cmdAddr_d;
         cmdDin_q  <= cmdDin_d;
         aRdata_q  <= aRdata_d;
         bRdata_q  <= bRdata_d;
         cnt_q     <= cnt_d;
         aDone_q   <= aDone_d;
         bDone_q   <= bDone_d;
         rdErr_q   <= rdErr_d;
      end
   end

   assign cmd_req  = cmdReq_q;
   assign cmd_mask = cmdMask_q;
   assign cmd_addr = cmdAddr_q;
   assign cmd_din  = cmdDin_q;
   assign a_rdata  = aRdata_q;
   assign b_rdata  = bRdata_q;
   assign a_done   = aDone_q;
   assign b_done   = bDone_q;
   assign rd_err   = rdErr_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: fixed-priority instance for the main traffic,
// plus a round-robin instance with an auto-acking controller for alternation.
`timescale 1ns/1ps
module tb_sdram_arb;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  mask;
      logic [31:0] addr;
      logic [15:0] din;
      bit          chkDin;
   } cmdExp_t;

   typedef struct {
      bit          isB;
      bit          isRead;
      logic [15:0] rdata;
   } doneExp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_wr, a_byte, a_done;
   logic [31:0] a_addr;
   logic [15:0] a_wdata, a_rdata;
   logic        b_req, b_wr, b_byte, b_done;
   logic [31:0] b_addr;
   logic [15:0] b_wdata, b_rdata;
   logic [1:0]  cmd_req, cmd_mask;
   logic        cmd_ack;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_din, cmd_dout;
   logic        data_valid, busy, rd_err;

   logic        rAReq, rBReq;
   logic        rAck = 1'b0;
   logic        rADone, rBDone, rBusy, rRdErr;
   logic [15:0] rARdata, rBRdata, rCmdDin;
   logic [1:0]  rCmdReq, rCmdMask;
   logic [31:0] rCmdAddr;

   int          checks = 0;
   int          errors = 0;
   cmdExp_t     cmdQ[$];
   doneExp_t    doneQ[$];
   bit          rrExp[$];
   int          rrServed = 0;
   int          aKeep = 0;
   int          bKeep = 0;
   logic [15:0] burst[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

   always #5 clk = ~clk;

   sdram_arb #(.RR(1'b0), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_wr(a_wr), .a_byte(a_byte), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_done(a_done),
      .b_req(b_req), .b_wr(b_wr), .b_byte(b_byte), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_done(b_done),
      .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_mask(cmd_mask), .cmd_addr(cmd_addr),
      .cmd_din(cmd_din), .cmd_dout(cmd_dout), .data_valid(data_valid),
      .busy(busy), .rd_err(rd_err)
   );

   sdram_arb #(.RR(1'b1), .TIMEOUT(255)) dutRr (
      .clk(clk), .reset(reset),
      .a_req(rAReq), .a_wr(1'b1), .a_byte(1'b0), .a_addr(32'h0000_00A0), .a_wdata(16'hAAAA),
      .a_rdata(rARdata), .a_done(rADone),
      .b_req(rBReq), .b_wr(1'b1), .b_byte(1'b0), .b_addr(32'h0000_00B0), .b_wdata(16'hBBBB),
      .b_rdata(rBRdata), .b_done(rBDone),
      .cmd_req(rCmdReq), .cmd_ack(rAck), .cmd_mask(rCmdMask), .cmd_addr(rCmdAddr),
      .cmd_din(rCmdDin), .cmd_dout(16'h0000), .data_valid(1'b0),
      .busy(rBusy), .rd_err(rRdErr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference command encoding: big-endian byte lanes, addr[0]=0 writes D15:8
   function automatic cmdExp_t modelCmd(input bit wr, input bit byt, input logic [31:0] addr,
                                        input logic [15:0] wdata);
      cmdExp_t m;
      m.addr   = addr;
      m.chkDin = wr;
      m.din    = 16'h0000;
      m.mask   = 2'b00;
      if (!wr) begin
         m.req = 2'b10;
      end else if (byt) begin
         m.req  = 2'b01;
         m.din  = {wdata[7:0], wdata[7:0]};
         m.mask = addr[0] ? 2'b10 : 2'b01;
      end else begin
         m.req = 2'b11;
         m.din = wdata;
      end
      return m;
   endfunction

   task automatic pushExp(input bit isB, input bit wr, input bit byt, input logic [31:0] addr,
                          input logic [15:0] wdata, input logic [15:0] expRd);
      doneExp_t d;
      cmdQ.push_back(modelCmd(wr, byt, addr, wdata));
      d.isB    = isB;
      d.isRead = !wr;
      d.rdata  = expRd;
      doneQ.push_back(d);
   endtask

   task automatic applyStimulus(input bit isB, input bit wr, input bit byt, input logic [31:0] addr,
                                input logic [15:0] wdata, input logic [15:0] expRd);
      pushExp(isB, wr, byt, addr, wdata, expRd);
      if (isB) begin
         b_wr = wr; b_byte = byt; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
      end else begin
         a_wr = wr; a_byte = byt; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Controller model: wait for a command, accept it after ackDelay cycles
   task automatic serveCmd(input int ackDelay, input bit isWrite);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (cmd_req != 2'b00) got = 1'b1;
         else tick();
      end
      checkOutput("cmd_seen", 32'(got), 32'd1);
      if (got) begin
         repeat (ackDelay) tick();
         cmd_ack = 1'b1;
         tick();
         cmd_ack = 1'b0;
         if (isWrite) begin
            checkOutput("wr_done_lat", 32'(a_done | b_done), 32'd1);
            checkOutput("req_drop", 32'(cmd_req), 32'd0);
         end
      end
   endtask

   task automatic handleDone(input bit isB);
      doneExp_t e;
      if (doneQ.size() == 0) begin
         checkOutput("done_unexp", 32'(isB ? b_done : a_done), 32'd0);
      end else begin
         e = doneQ.pop_front();
         checkOutput("done_port", 32'(isB), 32'(e.isB));
         if (e.isRead) checkOutput("rdata", 32'(isB ? b_rdata : a_rdata), 32'(e.rdata));
      end
      if (isB) begin
         if (bKeep > 0) bKeep--;
         else b_req = 1'b0;
      end else begin
         if (aKeep > 0) aKeep--;
         else a_req = 1'b0;
      end
   endtask

   // Command and completion monitor for the fixed-priority instance
   initial begin
      cmdExp_t cur;
      bit      curValid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            curValid = 1'b0;
         end else begin
            if (cmd_req != 2'b00) begin
               if (!curValid) begin
                  if (cmdQ.size() == 0) checkOutput("cmd_unexp", 32'(cmd_req), 32'd0);
                  else begin
                     cur      = cmdQ.pop_front();
                     curValid = 1'b1;
                  end
               end
               if (curValid) begin
                  checkOutput("cmd_req", 32'(cmd_req), 32'(cur.req));
                  checkOutput("cmd_mask", 32'(cmd_mask), 32'(cur.mask));
                  checkOutput("cmd_addr", cmd_addr, cur.addr);
                  if (cur.chkDin) checkOutput("cmd_din", 32'(cmd_din), 32'(cur.din));
               end
            end else begin
               curValid = 1'b0;
            end
            if (a_done) handleDone(1'b0);
            if (b_done) handleDone(1'b1);
         end
      end
   end

   // Round-robin instance: order check, and both requesters stop after four grants
   initial begin
      bit e;
      forever begin
         @(negedge clk);
         if (!reset && (rADone || rBDone)) begin
            if (rrExp.size() == 0) checkOutput("rr_unexp", 32'({rADone, rBDone}), 32'd0);
            else begin
               e = rrExp.pop_front();
               checkOutput("rr_order", 32'(rBDone), 32'(e));
            end
            rrServed++;
            if (rrServed == 4) begin
               rAReq = 1'b0;
               rBReq = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rAck = (rCmdReq != 2'b00) && !rAck;
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      a_req = 1'b0; a_wr = 1'b0; a_byte = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_wr = 1'b0; b_byte = 1'b0; b_addr = '0; b_wdata = '0;
      cmd_ack = 1'b0; cmd_dout = '0; data_valid = 1'b0;
      rAReq = 1'b0; rBReq = 1'b0;
      repeat (3) tick();
      checkOutput("rst_cmd", {12'd0, cmd_req, cmd_mask, cmd_din}, 32'd0);
      checkOutput("rst_addr", cmd_addr, 32'd0);
      checkOutput("rst_rdata", {a_rdata, b_rdata}, 32'd0);
      checkOutput("rst_flags", {28'd0, a_done, b_done, busy, rd_err}, 32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] word write A, byte writes B");
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1000, 16'hBEEF, 16'h0000);
      serveCmd(3, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2001, 16'h005A, 16'h0000);
      serveCmd(2, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000, 16'h005A, 16'h0000);
      serveCmd(0, 1'b1);
      tick();

      $display("[TB] read A with 4-word burst, B write queued during drain");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_3000, 16'h0000, 16'h1111);
      serveCmd(1, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         data_valid = 1'b1;
         cmd_dout   = burst[i];
         tick();
         if (i == 0) begin
            checkOutput("rd_done_lat", 32'(a_done), 32'd1);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_6000, 16'hCAFE, 16'h0000);
         end else begin
            checkOutput("drain_nocmd", {29'd0, busy, cmd_req}, 32'h4);
         end
      end
      data_valid = 1'b0;
      cmd_dout   = 16'h0000;
      serveCmd(2, 1'b1);
      tick();
      checkOutput("rderr_clear", 32'(rd_err), 32'd0);

      $display("[TB] read timeout");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_4000, 16'h0000, 16'h1111);
      serveCmd(1, 1'b0);
      n = 0;
      while (a_done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checkOutput("to_latency", n, 32'd255);
      checkOutput("rd_err_set", 32'(rd_err), 32'd1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_8000, 16'h1234, 16'h0000);
      serveCmd(1, 1'b1);
      tick();
      checkOutput("rd_err_sticky", 32'(rd_err), 32'd1);

      $display("[TB] contention, fixed priority");
      aKeep = 2;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_7000, 16'h0A0A, 16'h0000);
      pushExp(1'b0, 1'b1, 1'b0, 32'h0000_7000, 16'h0A0A, 16'h0000);
      pushExp(1'b0, 1'b1, 1'b0, 32'h0000_7000, 16'h0A0A, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_7100, 16'h0B0B, 16'h0000);
      for (int i = 0; i < 4; i++) serveCmd(1, 1'b1);
      tick();

      $display("[TB] contention, round robin");
      rrExp = '{1'b0, 1'b1, 1'b0, 1'b1};
      rAReq = 1'b1;
      rBReq = 1'b1;
      n = 0;
      while (rrServed < 4 && n < 100) begin
         tick();
         n++;
      end
      checkOutput("rr_served", rrServed, 32'd4);

      $display("[TB] reset during read");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_5000, 16'h0000, 16'h0000);
      serveCmd(1, 1'b0);
      repeat (3) tick();
      checkOutput("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_cmd", {12'd0, cmd_req, cmd_mask, cmd_din}, 32'd0);
      checkOutput("mid_rst_addr", cmd_addr, 32'd0);
      checkOutput("mid_rst_rdata", {a_rdata, b_rdata}, 32'd0);
      checkOutput("mid_rst_flags", {28'd0, a_done, b_done, busy, rd_err}, 32'd0);
      cmdQ.delete();
      doneQ.delete();
      a_req = 1'b0;
      tick();
      reset = 1'b0;
      data_valid = 1'b1;
      cmd_dout   = 16'h7777;
      repeat (3) tick();
      data_valid = 1'b0;
      repeat (3) tick();
      checkOutput("post_rst_idle", {15'd0, busy, a_rdata}, 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_A000, 16'h0000, 16'h9999);
      serveCmd(1, 1'b0);
      data_valid = 1'b1;
      cmd_dout   = 16'h9999;
      tick();
      data_valid = 1'b0;
      checkOutput("post_rst_done", 32'(a_done), 32'd1);
      repeat (5) tick();
      checkOutput("sb_cmd_empty", cmdQ.size(), 32'd0);
      checkOutput("sb_done_empty", doneQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
- Two-port request arbiter and front-end that sits directly upstream of the tiny SDRAM controller and drives its cmd_* interface.
- Port A is the Saturn bus side and has priority by default. Port B is the MCU/DMA side.
- Converts held per-port requests into the controller's cmd_req encoding, generates byte lane masks, and holds address/data stable until cmd_ack.
- Captures the first word of each read burst and returns one-cycle done pulses to the granted port.

Parameters:
- RR, 0, 1 = round-robin between A and B (last-granted port loses ties); 0 = fixed priority A over B.
- TIMEOUT, 255, cycles allowed in ST_RDAT waiting for data_valid before the read is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; held high until a_done.
- a_wr  in  1  1 = write, 0 = read; sampled at grant.
- a_byte  in  1  1 = byte write (uses a_addr[0]); ignored for reads.
- a_addr  in  32  byte address.
- a_wdata  in  16  write data; byte write uses [7:0].
- a_rdata  out  16  read word, valid when a_done pulses after a read.
- a_done  out  1  one-cycle completion pulse.
- b_req, b_wr, b_byte, b_addr, b_wdata, b_rdata, b_done: same widths and meanings, port B.
- cmd_req  out  2  to controller: 00 nop, 01 write byte, 11 write word, 10 read.
- cmd_ack  in  1  controller one-cycle accept pulse.
- cmd_mask  out  2  DQM; a 1 masks that byte lane ([1]=D15:8, [0]=D7:0).
- cmd_addr  out  32  address to controller.
- cmd_din  out  16  write data to controller.
- cmd_dout  in  16  read data from controller.
- data_valid  in  1  high for the burst words of a read.
- busy  out  1  high whenever state != ST_IDLE.
- rd_err  out  1  sticky; set on read timeout, cleared only by reset.

Behaviour:
- Reset: state=ST_IDLE, cmd_req=00, cmd_mask=00, cmd_addr=0, cmd_din=0, a_rdata=b_rdata=0, a_done=b_done=0, busy=0, rd_err=0, RR pointer=A. Asserting reset mid-operation drops cmd_req immediately; no done pulse is produced for the lost request.
- State ST_IDLE:
  - If either req is high, pick the winner. RR=0: A wins. RR=1: when both are high, the port not granted last wins; otherwise the single requester wins.
  - Latch sel, wr, byte, addr and wdata from the winner; go to ST_ISSUE next cycle.
  - A request that rises while another is in service waits; it is never dropped.
- Command formation, registered at grant:
  - cmd_addr = latched addr.
  - Read: cmd_req=10, cmd_mask=00.
  - Word write: cmd_req=11, cmd_mask=00, cmd_din=wdata.
  - Byte write: cmd_req=01, cmd_din={wdata[7:0],wdata[7:0]}. Big-endian: addr[0]=0 gives mask 01 (write D15:8); addr[0]=1 gives mask 10 (write D7:0).
- State ST_ISSUE: hold cmd_req, cmd_addr, cmd_din and cmd_mask constant until cmd_ack=1. On the ack cycle, cmd_req becomes 00 on the next edge.
  - Write: pulse x_done in the cycle after ack, then go to ST_IDLE.
  - Read: go to ST_RDAT.
- State ST_RDAT:
  - On the first cycle with data_valid=1, register cmd_dout into x_rdata.
  - Pulse x_done in the following cycle, then go to ST_DRAIN.
  - Remaining burst words (BL-1) are discarded.
  - If the count reaches TIMEOUT with no data_valid: set rd_err, pulse x_done with x_rdata unchanged, go to ST_IDLE.
- State ST_DRAIN: wait until data_valid=0, then go to ST_IDLE. This keeps a stale burst from being captured by the next read.
- data_valid outside ST_RDAT/ST_DRAIN: ignored.
- Done pulse: x_done is high for exactly one cycle. The requester must drop x_req in the cycle after x_done; if x_req is still high in ST_IDLE it is treated as a new request.
- RR pointer: updated at grant.
- Timeout counter: 8 bits, saturating, cleared on ST_RDAT entry.
- Latency:
  - Write: grant +1 to cmd_req, done 1 cycle after cmd_ack.
  - Read: done 1 cycle after the first data_valid.
- Only one command is outstanding at any time.

Test Plan:
- Word write A: a_req, a_wr=1, a_addr=0x00001000, a_wdata=0xBEEF; ack after 3 cycles -> cmd_req=11, cmd_addr=0x1000, cmd_din=0xBEEF, mask 00, stable until ack; a_done one cycle after ack; cmd_req=00 after.
- Byte writes B: b_addr=0x2001, b_wdata=0x005A -> cmd_req=01, cmd_din=0x5A5A, mask=10. Repeat with b_addr=0x2000 -> mask=01.
- Read A: a_wr=0; controller asserts data_valid for 4 cycles with 0x1111, 0x2222, 0x3333, 0x4444 -> a_rdata=0x1111, a_done exactly once; next read waits until data_valid falls.
- Contention: a_req and b_req rise in the same cycle. RR=0 -> A, A, A while A stays requesting. RR=1 -> A, B, A alternation; neither request is lost.
- Timeout: read with data_valid never asserted -> rd_err=1 and a_done after 255 cycles in ST_RDAT; the next request is served normally.
- Reset mid-read: assert reset in ST_RDAT -> cmd_req=00, all outputs at reset values; no a_done pulse after release.
